ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Parametrised PS/2 set-2 scan-code decoder that succeeds the single-character keyboard controller. It takes parity-tagged bytes from the PS/2 receive front end, tracks make/break/extended prefixes and modifier state, and maps make codes to ASCII. Decoded characters are buffered in an output FIFO with a valid/ready handshake toward the consumer (UART bridge, text console).

## Interface
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, 2 or greater.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of fifo_count.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- scan_code_p  in  9  [7:0] scan byte, [8] odd-parity bit.
- valid  in  1  one-cycle strobe: scan_code_p is valid this cycle.
- ascii  out  8  FIFO head character; 0x00 when the FIFO is empty.
- ascii_valid  out  1  FIFO is not empty.
- ascii_ready  in  1  consumer accepts the head entry when ascii_valid is also high.
- parity_err  out  1  one-cycle pulse when a byte fails the parity check.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- shift_active  out  1  left or right shift is held.
- caps_lock  out  1  caps-lock toggle state.
- fifo_count  out  CNT_W  current number of FIFO entries.

## Operation
- Parity check: a byte is good when the XOR of all 9 bits is 1. A bad byte is dropped, pulses parity_err, and returns the FSM to IDLE, discarding any pending prefix.
- Prefix FSM has four states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - IDLE: F0 goes to BRK; E0 goes to EXT; any other byte is decoded as a make code and the FSM stays in IDLE.
  - BRK: the next byte is a break code. It clears the shift flag for 0x12 or 0x59, then the FSM goes to IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte is consumed with no output and no modifier change, then the FSM goes to IDLE.
  - EXT_BRK: the next byte is consumed, then the FSM goes to IDLE.
- Make codes:
  - 0x12 and 0x59 set lshift and rshift respectively; no output.
  - Letters map to 'a'..'z'. Uppercase is produced when shift_active XOR caps_lock.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9' and ignore shift.
  - 0x29 maps to 0x20, 0x5A to 0x0D, 0x66 to 0x08.
  - Unmapped codes are dropped silently.
- Typematic repeat: a repeated make code produces another character.
- FIFO is show-ahead: ascii is the head entry. A pop occurs when ascii_valid and ascii_ready are both high.
- Push into a full FIFO: the character is dropped and overflow is set. The exception is a pop in the same cycle, in which case the push is accepted and count is unchanged.
- Simultaneous push and pop when not full: count is unchanged and ordering is preserved.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: FSM IDLE, lshift/rshift/caps 0, FIFO empty, ascii 0x00, ascii_valid 0, parity_err 0, overflow 0, shift_active 0, caps_lock 0, fifo_count 0.
- Reset mid-sequence flushes the FIFO and any pending prefix.
- Decode is registered. A byte sampled at edge N is written to the FIFO at edge N+1. ascii_valid rises after edge N+1 when the FIFO was empty, giving 2-cycle latency.
- parity_err is high for the single cycle after the sampling edge.
- Modifier outputs update at edge N.
- valid may be asserted on consecutive cycles; every strobe is processed, with no back-pressure on the input.
- A pop at edge M updates ascii, ascii_valid and fifo_count after edge M.

## Configuration
- PS2_DEC_CAPSLOCK_EN defined: make 0x58 toggles caps_lock (break is ignored), and caps_lock affects letter case.
- Undefined: 0x58 is an unmapped code, caps_lock is tied to 0, and case depends on shift only.

## Test plan
- Reset, ascii_ready=1, send 9'h01C: ascii=0x61 with ascii_valid high exactly 2 cycles after the strobe, then the FIFO is empty.
- Send 9'h112, 9'h01C, 9'h1F0, 9'h112, 9'h01C: outputs are 0x41 then 0x61, and shift_active drops after the break.
- Send 9'h11C: parity_err pulses once, no character is produced, and fifo_count stays 0.
- FIFO_DEPTH=4, ascii_ready=0, five strobes of 9'h01C: fifo_count=4, overflow=1. Raising ascii_ready yields four 0x61 and overflow stays 1.
- Send 9'h0E0, 9'h075, 9'h0E0, 9'h1F0, 9'h075, 9'h01C: only 0x61 is output.
- With PS2_DEC_CAPSLOCK_EN, send 9'h058, 9'h032: output 0x42. Adding held shift (9'h112) then 9'h032 gives 0x62.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns parity-tagged PS/2 set-2 scan bytes into ASCII characters. The
// decoder tracks the F0 (break) and E0 (extended) prefixes, keeps the
// left/right shift state (and optionally caps lock), and maps make codes for
// letters, digits, space, enter and backspace to ASCII. Decoded characters
// go into a show-ahead FIFO that the consumer drains with a valid/ready
// handshake.
//
// Optional feature macro: PS2_DEC_CAPSLOCK_EN
//   defined   - make code 0x58 toggles caps_lock, and caps_lock flips letter case
//   undefined - 0x58 is an ordinary unmapped code and caps_lock is tied low
//
// Parameters:
//   FIFO_DEPTH   output FIFO entries (power of two, >= 2)
//   CNT_W        width of fifo_count
//
// Ports:
//   clk           system clock, everything on its rising edge
//   rst           synchronous active-high reset
//   scan_code_p   [7:0] scan byte, [8] odd-parity bit
//   valid         one-cycle strobe qualifying scan_code_p
//   ascii         FIFO head character, 0x00 when empty
//   ascii_valid   FIFO not empty
//   ascii_ready   consumer takes the head entry when ascii_valid is high
//   parity_err    one-cycle pulse after a byte with bad parity
//   overflow      sticky: a character was dropped on a full FIFO
//   shift_active  either shift key held
//   caps_lock     caps-lock toggle state
//   fifo_count    number of entries in the FIFO

module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       scan_code_p,
    input  logic             valid,
    output logic [7:0]       ascii,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic             parity_err,
    output logic             overflow,
    output logic             shift_active,
    output logic             caps_lock,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
`ifdef PS2_DEC_CAPSLOCK_EN
    localparam logic [7:0] CODE_CAPS   = 8'h58;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t state_q, state_d;

    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;
    logic caps_eff;
`ifdef PS2_DEC_CAPSLOCK_EN
    logic caps_q, caps_d;
`endif

    // One-stage decode pipeline between the byte input and the FIFO
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] pend_char_q, pend_char_d;
    logic       perr_q, perr_d;

    logic [7:0] scan_byte;
    logic       parity_ok;

    logic       map_hit;
    logic [7:0] map_char;
    logic       letter_hit;
    logic [7:0] letter_lc;
    logic       upper_sel;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             push_drop;

    assign scan_byte = scan_code_p[7:0];
    // Odd parity: the nine bits together must XOR to one
    assign parity_ok = ^scan_code_p;

`ifdef PS2_DEC_CAPSLOCK_EN
    assign caps_eff = caps_q;
`else
    assign caps_eff = 1'b0;
`endif

    assign upper_sel = (lshift_q | rshift_q) ^ caps_eff;

    // Letter lookup: set-2 make code to lowercase ASCII
    always_comb begin
        letter_hit = 1'b1;
        letter_lc  = 8'h00;
        case (scan_byte)
            8'h1C: letter_lc = "a";
            8'h32: letter_lc = "b";
            8'h21: letter_lc = "c";
            8'h23: letter_lc = "d";
            8'h24: letter_lc = "e";
            8'h2B: letter_lc = "f";
            8'h34: letter_lc = "g";
            8'h33: letter_lc = "h";
            8'h43: letter_lc = "i";
            8'h3B: letter_lc = "j";
            8'h42: letter_lc = "k";
            8'h4B: letter_lc = "l";
            8'h3A: letter_lc = "m";
            8'h31: letter_lc = "n";
            8'h44: letter_lc = "o";
            8'h4D: letter_lc = "p";
            8'h15: letter_lc = "q";
            8'h2D: letter_lc = "r";
            8'h1B: letter_lc = "s";
            8'h2C: letter_lc = "t";
            8'h3C: letter_lc = "u";
            8'h2A: letter_lc = "v";
            8'h1D: letter_lc = "w";
            8'h22: letter_lc = "x";
            8'h35: letter_lc = "y";
            8'h1A: letter_lc = "z";
            default: letter_hit = 1'b0;
        endcase
    end

    // Full character map. Letters pick their case from shift XOR caps;
    // digits and control characters ignore modifiers.
    always_comb begin
        map_hit  = 1'b1;
        map_char = 8'h00;
        if (letter_hit) begin
            map_char = upper_sel ? (letter_lc - 8'h20) : letter_lc;
        end else begin
            case (scan_byte)
                8'h45: map_char = "0";
                8'h16: map_char = "1";
                8'h1E: map_char = "2";
                8'h26: map_char = "3";
                8'h25: map_char = "4";
                8'h2E: map_char = "5";
                8'h36: map_char = "6";
                8'h3D: map_char = "7";
                8'h3E: map_char = "8";
                8'h46: map_char = "9";
                8'h29: map_char = 8'h20;
                8'h5A: map_char = 8'h0D;
                8'h66: map_char = 8'h08;
                default: map_hit = 1'b0;
            endcase
        end
    end

    // Prefix FSM and modifier tracking. A bad-parity byte abandons any
    // half-received prefix so the next good byte starts from scratch.
    always_comb begin
        state_d      = state_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
`ifdef PS2_DEC_CAPSLOCK_EN
        caps_d       = caps_q;
`endif
        pend_valid_d = 1'b0;
        pend_char_d  = 8'h00;
        perr_d       = 1'b0;
        if (valid) begin
            if (!parity_ok) begin
                perr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (scan_byte == CODE_BRK) begin
                            state_d = BRK;
                        end else if (scan_byte == CODE_EXT) begin
                            state_d = EXT;
                        end else if (scan_byte == CODE_LSHIFT) begin
                            lshift_d = 1'b1;
                        end else if (scan_byte == CODE_RSHIFT) begin
                            rshift_d = 1'b1;
`ifdef PS2_DEC_CAPSLOCK_EN
                        end else if (scan_byte == CODE_CAPS) begin
                            caps_d = ~caps_q;
`endif
                        end else if (map_hit) begin
                            pend_valid_d = 1'b1;
                            pend_char_d  = map_char;
                        end
                    end
                    BRK: begin
                        if (scan_byte == CODE_LSHIFT) begin
                            lshift_d = 1'b0;
                        end
                        if (scan_byte == CODE_RSHIFT) begin
                            rshift_d = 1'b0;
                        end
                        state_d = IDLE;
                    end
                    EXT: begin
                        // Extended keys (arrows etc.) have no ASCII meaning here
                        state_d = (scan_byte == CODE_BRK) ? EXT_BRK : IDLE;
                    end
                    EXT_BRK: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Decoder state register: FSM, modifiers and the pending character
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
`ifdef PS2_DEC_CAPSLOCK_EN
            caps_q       <= 1'b0;
`endif
            pend_valid_q <= 1'b0;
            pend_char_q  <= 8'h00;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
`ifdef PS2_DEC_CAPSLOCK_EN
            caps_q       <= caps_d;
`endif
            pend_valid_q <= pend_valid_d;
            pend_char_q  <= pend_char_d;
            perr_q       <= perr_d;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && ascii_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle
    assign push_ok    = pend_valid_q && (!fifo_full || pop);
    assign push_drop  = pend_valid_q && fifo_full && !pop;

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= pend_char_q;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag. Pointers are
    // exactly log2(depth) bits wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign ascii        = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign ascii_valid  = !fifo_empty;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign parity_err   = perr_q;
    assign shift_active = lshift_q | rshift_q;
    assign caps_lock    = caps_eff;

endmodule
